// File: rtl/config_int_add_clkgate_pipe_if.sv
// rtl/config_int_add_clkgate_pipe_if.sv - operand, config and result signals of the approximate adder
// acc_mode exists only when APX_ACC_EN is defined.
interface config_int_add_clkgate_pipe_if #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int CFGW = $clog2(DATA_PATH_BITWIDTH) + 1
);
  logic                          reg_en;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] a;
  logic [DATA_PATH_BITWIDTH-1:0] b;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [CFGW-1:0]               cfg_apx_bits;
  logic [CFGW-1:0]               apx_bits_o;
  logic [DATA_PATH_BITWIDTH-1:0] c;
  logic                          carry_o;
  logic                          out_valid;
`ifdef APX_ACC_EN
  logic                          acc_mode;
`endif

  modport master (
`ifdef APX_ACC_EN
    output acc_mode,
`endif
    output reg_en, in_valid, a, b, cfg_valid, cfg_apx_bits,
    input  in_ready, cfg_ready, apx_bits_o, c, carry_o, out_valid
  );

  modport slave (
`ifdef APX_ACC_EN
    input  acc_mode,
`endif
    input  reg_en, in_valid, a, b, cfg_valid, cfg_apx_bits,
    output in_ready, cfg_ready, apx_bits_o, c, carry_o, out_valid
  );
endinterface

// File: rtl/config_int_add_clkgate_pipe.sv
// rtl/config_int_add_clkgate_pipe.sv - 2-stage clock-gated approximate adder with runtime LSB count
// Optional accumulate mode is enabled by the APX_ACC_EN macro.
module config_int_add_clkgate_pipe #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int MAX_APX_BITS       = 16,
  parameter int DEFAULT_APX_BITS   = 0,
  parameter int CFGW               = $clog2(DATA_PATH_BITWIDTH) + 1
) (
  input logic                        clk,
  input logic                        rst,
  config_int_add_clkgate_pipe_if.slave bus
);
  localparam int W = DATA_PATH_BITWIDTH;

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;
  state_t state_q;

  logic [W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic            carry_q, carry_d;
  logic            v1_q, v1_d;
  logic            out_valid_q, out_valid_d;
  logic [CFGW-1:0] apx_q, apx_d, pend_q, pend_d;
  logic [W-1:0]    keep_mask, new_mask;
  logic [W:0]      sum;
  logic            in_acc, cfg_acc;

  assign bus.in_ready   = bus.reg_en && (state_q == RUN);
  assign bus.cfg_ready  = bus.reg_en && (state_q == RUN);
  assign bus.apx_bits_o = apx_q;
  assign bus.c          = c_q;
  assign bus.carry_o    = carry_q;
  // A pulse frozen by reg_en=0 stays pending and is shown once the block resumes.
  assign bus.out_valid  = out_valid_q && bus.reg_en;

  assign in_acc    = bus.in_valid && bus.in_ready;
  assign cfg_acc   = bus.cfg_valid && bus.cfg_ready;
  assign keep_mask = {W{1'b1}} << apx_q;
  assign new_mask  = {W{1'b1}} << pend_q;

  always_comb begin
    sum = {1'b0, a_q & keep_mask} + {1'b0, b_q & keep_mask};
`ifdef APX_ACC_EN
    if (bus.acc_mode) sum = sum + {1'b0, c_q};
`endif
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    carry_d     = carry_q;
    v1_d        = v1_q;
    out_valid_d = out_valid_q;
    apx_d       = apx_q;
    pend_d      = pend_q;
    if (bus.reg_en) begin
      v1_d        = in_acc;
      out_valid_d = v1_q;
      // Gated LSB flops are never loaded, so they keep the zero written at reset/APPLY.
      if (in_acc) begin
        a_d = (bus.a & keep_mask) | (a_q & ~keep_mask);
        b_d = (bus.b & keep_mask) | (b_q & ~keep_mask);
      end
      if (v1_q) {carry_d, c_d} = sum;
      if (cfg_acc) begin
        pend_d = (bus.cfg_apx_bits > CFGW'(MAX_APX_BITS)) ? CFGW'(MAX_APX_BITS)
                                                          : bus.cfg_apx_bits;
      end
      if (state_q == APPLY) begin
        apx_d = pend_q;
        a_d   = a_q & new_mask;
        b_d   = b_q & new_mask;
`ifdef APX_ACC_EN
        c_d     = '0;
        carry_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      carry_q     <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      apx_q       <= CFGW'(DEFAULT_APX_BITS);
      pend_q      <= CFGW'(DEFAULT_APX_BITS);
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      apx_q       <= apx_d;
      pend_q      <= pend_d;
      if (bus.reg_en) begin
        unique case (state_q)
          RUN:     if (cfg_acc) state_q <= DRAIN;
          // Nothing is accepted in DRAIN, so v1 is always empty after one edge.
          DRAIN:   if (!v1_d) state_q <= APPLY;
          APPLY:   state_q <= RUN;
          default: state_q <= RUN;
        endcase
      end
    end
  end
endmodule
